multiport_register_file: RTL and testbench

MULTIPORT_REGISTER_FILE -- requirements
Module: multiport_register_file

---
 rtl/multiport_register_file.sv | 106 ++++++++++
 tb/tb_multiport_register_file.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/multiport_register_file.sv
// Multiport register file with a registered read path per port, optional
// write-to-read forwarding, optional hard-wired zero register and a sequential clear sweep.
module multiport_register_file #(
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_REGISTERS  = 32,
  parameter int NUM_READ_PORTS = 2,
  parameter int ZERO_REG       = 1,
  parameter int BYPASS         = 1,
  localparam int ADDR_W = ($clog2(NUM_REGISTERS) < 1) ? 1 : $clog2(NUM_REGISTERS)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_READ_PORTS*ADDR_W-1:0]     raddr,
  output logic [NUM_READ_PORTS*DATA_WIDTH-1:0] rdata,
  input  logic                                 we,
  input  logic [ADDR_W-1:0]                    waddr,
  input  logic [DATA_WIDTH-1:0]                wdata,
  input  logic                                 clear,
  output logic                                 busy,
  output logic                                 wr_err
);

  typedef enum logic {CLEARING, READY} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGISTERS - 1);

  state_t                state, state_next;
  logic [ADDR_W-1:0]     idx, idx_next;
  logic [DATA_WIDTH-1:0] regs [NUM_REGISTERS];
  logic                  write_ok;

  // Address decodes to a real, writable/readable register (not out of range, not hard zero).
  function automatic logic addressable(input logic [ADDR_W-1:0] a);
    return (32'(a) < 32'(NUM_REGISTERS)) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEARING;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    case (state)
      CLEARING: begin
        idx_next = idx + 1'b1;
        if (idx == LAST_IDX) state_next = READY;
      end
      READY: begin
        if (clear) begin
          state_next = CLEARING;
          idx_next   = '0;
        end
      end
      default: begin
        state_next = CLEARING;
        idx_next   = '0;
      end
    endcase
  end

  assign busy     = (state == CLEARING);
  assign write_ok = !rst && (state == READY) && we && !clear && addressable(waddr);

  // Array has no reset; zeroing comes only from the sweep.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEARING) regs[idx] <= '0;
      else if (write_ok)     regs[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) wr_err <= 1'b0;
    else     wr_err <= we && ((state == CLEARING) || clear);
  end

  for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_rd
    logic [ADDR_W-1:0]     ra;
    logic [DATA_WIDTH-1:0] rd_next, rd_q;

    assign ra = raddr[p*ADDR_W +: ADDR_W];

    always_comb begin
      rd_next = '0;
      if ((state == READY) && addressable(ra)) begin
        if ((BYPASS != 0) && write_ok && (waddr == ra)) rd_next = wdata;
        else                                            rd_next = regs[ra];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) rd_q <= '0;
      else     rd_q <= rd_next;
    end

    assign rdata[p*DATA_WIDTH +: DATA_WIDTH] = rd_q;
  end

endmodule

// File: tb/tb_multiport_register_file.sv
// Bench for multiport_register_file: two configurations driven by shared stimulus,
// each compared every cycle against an abstract reference model.
module tb_multiport_register_file;

  logic        clk;
  logic        rst;
  logic [9:0]  raddr;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        clear;
  logic [63:0] rdata_a, rdata_b;
  logic        busy_a, busy_b, wr_err_a, wr_err_b;

  int vectors = 0;
  int errors  = 0;

  multiport_register_file dut_a (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata_a), .we(we), .waddr(waddr),
    .wdata(wdata), .clear(clear), .busy(busy_a), .wr_err(wr_err_a)
  );

  multiport_register_file #(
    .DATA_WIDTH(32), .NUM_REGISTERS(24), .NUM_READ_PORTS(2), .ZERO_REG(0), .BYPASS(0)
  ) dut_b (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata_b), .we(we), .waddr(waddr),
    .wdata(wdata), .clear(clear), .busy(busy_b), .wr_err(wr_err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: per-instance memory and remaining busy cycles.
  int          nregs [2] = '{32, 24};
  bit          zr    [2] = '{1'b1, 1'b0};
  bit          byp   [2] = '{1'b1, 1'b0};
  logic [31:0] mem   [2][32];
  int          clear_left [2];
  logic [31:0] exp_rd  [2][2];
  logic        exp_err [2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_update();
    logic [4:0] a;
    bit acc;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        clear_left[i] = nregs[i];
        exp_err[i] = 1'b0;
        for (int p = 0; p < 2; p++) exp_rd[i][p] = '0;
      end else if (clear_left[i] > 0) begin
        exp_err[i] = we;
        for (int p = 0; p < 2; p++) exp_rd[i][p] = '0;
        mem[i][nregs[i] - clear_left[i]] = '0;
        clear_left[i]--;
      end else begin
        acc = we && !clear && (int'(waddr) < nregs[i]) && !(zr[i] && waddr == 0);
        for (int p = 0; p < 2; p++) begin
          a = raddr[p*5 +: 5];
          if (int'(a) >= nregs[i] || (zr[i] && a == 0)) exp_rd[i][p] = '0;
          else if (byp[i] && acc && waddr == a)          exp_rd[i][p] = wdata;
          else                                           exp_rd[i][p] = mem[i][a];
        end
        exp_err[i] = we && clear;
        if (acc) mem[i][waddr] = wdata;
        if (clear) clear_left[i] = nregs[i];
      end
    end
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    check("busy_a", 64'(busy_a), 64'(clear_left[0] != 0));
    check("busy_b", 64'(busy_b), 64'(clear_left[1] != 0));
    check("wr_err_a", 64'(wr_err_a), 64'(exp_err[0]));
    check("wr_err_b", 64'(wr_err_b), 64'(exp_err[1]));
    for (int p = 0; p < 2; p++) begin
      check("rdata_a", 64'(rdata_a[p*32 +: 32]), 64'(exp_rd[0][p]));
      check("rdata_b", 64'(rdata_b[p*32 +: 32]), 64'(exp_rd[1][p]));
    end
  endtask

  task automatic idle();
    we = 1'b0; clear = 1'b0; rst = 1'b0;
  endtask

  int cnt_a, cnt_b;

  initial begin
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 32; j++) mem[i][j] = '0;
    rst = 1'b1; we = 1'b0; clear = 1'b0; waddr = '0; wdata = '0; raddr = '0;
    step();
    check("reset_busy", 64'(busy_a), 64'd1);
    check("reset_rdata", rdata_a, 64'd0);
    step();

    // Clear sweep length after reset release.
    idle();
    cnt_a = busy_a ? 1 : 0;
    cnt_b = busy_b ? 1 : 0;
    for (int k = 0; k < 100 && (busy_a || busy_b); k++) begin
      raddr = 10'($urandom);
      step();
      if (busy_a) cnt_a++;
      if (busy_b) cnt_b++;
    end
    check("busy_len_a", 64'(cnt_a), 64'd32);
    check("busy_len_b", 64'(cnt_b), 64'd24);

    // Write r5 then read on both ports.
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; step();
    we = 1'b0; raddr = {5'd5, 5'd5}; step();
    check("r5_p0", 64'(rdata_a[31:0]), 64'hDEADBEEF);
    check("r5_p1", 64'(rdata_a[63:32]), 64'hDEADBEEF);

    // Same-cycle write/read of r7: forwarded on A, old value on B.
    we = 1'b1; waddr = 5'd7; wdata = 32'h11111111; step();
    wdata = 32'h12345678; raddr = {5'd7, 5'd7}; step();
    check("bypass_a", 64'(rdata_a[31:0]), 64'h12345678);
    check("nobypass_b", 64'(rdata_b[31:0]), 64'h11111111);
    we = 1'b0; step();
    check("r7_after_b", 64'(rdata_b[63:32]), 64'h12345678);

    // Hard-wired r0 on A.
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; raddr = '0; step();
    check("r0_no_err", 64'(wr_err_a), 64'd0);
    we = 1'b0; step();
    check("r0_read_a", 64'(rdata_a[31:0]), 64'd0);

    // Clear wins over a concurrent write.
    we = 1'b1; waddr = 5'd3; wdata = 32'h00000055; step();
    clear = 1'b1; wdata = 32'hA5A5A5A5; step();
    check("clr_wr_err", 64'(wr_err_a), 64'd1);
    idle();
    cnt_a = busy_a ? 1 : 0;
    for (int k = 0; k < 100 && busy_a; k++) begin
      step();
      if (busy_a) cnt_a++;
    end
    check("clr_len_a", 64'(cnt_a), 64'd32);
    raddr = {5'd3, 5'd3}; step();
    check("r3_cleared", 64'(rdata_a[31:0]), 64'd0);

    // Out-of-range address on the 24-entry instance.
    we = 1'b1; waddr = 5'd30; wdata = 32'hCAFEF00D; step();
    we = 1'b0; raddr = {5'd30, 5'd30}; step();
    check("oor_b", 64'(rdata_b[31:0]), 64'd0);

    // Randomized traffic including rare clears and resets.
    for (int n = 0; n < 3000; n++) begin
      rst   = ($urandom_range(0, 299) == 0);
      clear = ($urandom_range(0, 79) == 0);
      we    = 1'($urandom);
      waddr = 5'($urandom);
      wdata = $urandom;
      for (int p = 0; p < 2; p++)
        raddr[p*5 +: 5] = ($urandom_range(0, 1) == 1) ? waddr : 5'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
